// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage.
// Reads one word per instruction from instruction memory, presents
// {pc, inst, fetch_err} to decode, then waits for write-back to return
// the next PC. A misaligned next PC is turned into a faulting NOP
// without touching memory.
// Optional performance counters are built when IFU_PERF_EN is defined;
// otherwise perf_fetch_cnt/perf_stall_cnt are tied to zero.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_araddr,
  output logic        imem_arvalid,
  input  logic        imem_arready,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  input  logic        imem_rvalid,
  output logic        imem_rready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        fetch_err,
  output logic        valid_out_idu,
  input  logic        ready_in_idu,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic        ready_out_wbu,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    REQ      = 3'd1,
    RESP     = 3'd2,
    SEND     = 3'd3,
    WAIT_NPC = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic xfer_idu;
  logic npc_misaligned;

  assign xfer_idu       = (state == SEND) && ready_in_idu;
  assign npc_misaligned = (npc[1:0] != 2'b00);

  // Handshake outputs come straight from the state so they are glitch-free.
  assign imem_arvalid  = (state == REQ);
  assign imem_rready   = (state == RESP);
  assign valid_out_idu = (state == SEND);
  assign ready_out_wbu = (state == WAIT_NPC);
  assign imem_araddr   = {pc[31:2], 2'b00};

  // State register; reset parks the stage in BOOT so memory sees no request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one instruction walks REQ -> RESP -> SEND -> WAIT_NPC.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:     state_nxt = REQ;
      REQ:      if (imem_arready) state_nxt = RESP;
      RESP:     if (imem_rvalid) state_nxt = SEND;
      SEND:     if (ready_in_idu) state_nxt = WAIT_NPC;
      WAIT_NPC: begin
        if (npc_valid) begin
          state_nxt = npc_misaligned ? SEND : REQ;
        end
      end
      default:  state_nxt = BOOT;
    endcase
  end

  // Payload registers: captured from memory or write-back, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= NOP_INST;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        RESP: begin
          if (imem_rvalid) begin
            if (imem_rresp == 2'b00) begin
              inst      <= imem_rdata;
              fetch_err <= 1'b0;
            end else begin
              inst      <= NOP_INST;
              fetch_err <= 1'b1;
            end
          end
        end
        WAIT_NPC: begin
          if (npc_valid) begin
            pc <= npc;
            if (npc_misaligned) begin
              inst      <= NOP_INST;
              fetch_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  // Free-running wrap-around counters of decode transfers and memory waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (xfer_idu) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if ((state == REQ) || (state == RESP)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch with a delay-configurable
// instruction memory model. Expected {pc, inst, fetch_err} is queued when
// an instruction is started and popped when decode sees valid.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h80000000;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic        clk;
  logic        rst;
  logic [31:0] imem_araddr;
  logic        imem_arvalid;
  logic        imem_arready;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rvalid;
  logic        imem_rready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        fetch_err;
  logic        valid_out_idu;
  logic        ready_in_idu;
  logic [31:0] npc;
  logic        npc_valid;
  logic        ready_out_wbu;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   exp_fetch = 0;
  int   exp_stall = 0;

  int          ar_delay = 0;
  int          r_delay = 0;
  logic [1:0]  resp_mode = 2'b00;
  bit          spur_rvalid = 1'b0;
  int          mem_phase = 0;
  int          ar_wait = 0;
  int          r_wait = 0;
  logic [31:0] lat_addr = 32'h0;

  ifu_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk(clk),
    .rst(rst),
    .imem_araddr(imem_araddr),
    .imem_arvalid(imem_arvalid),
    .imem_arready(imem_arready),
    .imem_rdata(imem_rdata),
    .imem_rresp(imem_rresp),
    .imem_rvalid(imem_rvalid),
    .imem_rready(imem_rready),
    .pc(pc),
    .inst(inst),
    .fetch_err(fetch_err),
    .valid_out_idu(valid_out_idu),
    .ready_in_idu(ready_in_idu),
    .npc(npc),
    .npc_valid(npc_valid),
    .ready_out_wbu(ready_out_wbu),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  // 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instFor(input logic [31:0] a);
    return 32'h00100093 ^ {a[15:0], 16'h0000};
  endfunction

  // Memory model: reacts 2 units after each rising edge, after the main
  // process has driven and sampled, so the two never race.
  initial begin
    imem_arready = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    imem_rresp   = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        mem_phase    = 0;
        ar_wait      = 0;
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
      end else begin
        case (mem_phase)
          0: begin
            imem_arready = 1'b0;
            imem_rvalid  = 1'b0;
            if (imem_arvalid) begin
              if (spur_rvalid) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEADBEEF;
                imem_rresp  = 2'b00;
              end
              if (ar_wait >= ar_delay) begin
                imem_arready = 1'b1;
                lat_addr     = imem_araddr;
                mem_phase    = 1;
                r_wait       = 0;
              end else begin
                ar_wait++;
              end
            end
          end
          1: begin
            imem_arready = 1'b0;
            imem_rvalid  = 1'b0;
            if (r_wait >= r_delay) begin
              imem_rvalid = 1'b1;
              imem_rdata  = instFor(lat_addr);
              imem_rresp  = resp_mode;
              mem_phase   = 2;
            end else begin
              r_wait++;
            end
          end
          default: begin
            imem_rvalid = 1'b0;
            mem_phase   = 0;
            ar_wait     = 0;
          end
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    cmp_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic checkPerf();
`ifdef IFU_PERF_EN
    checkOutput("perf_fetch", perf_fetch_cnt, 32'(exp_fetch));
    checkOutput("perf_stall", perf_stall_cnt, 32'(exp_stall));
`else
    checkOutput("perf_fetch_off", perf_fetch_cnt, 32'd0);
    checkOutput("perf_stall_off", perf_stall_cnt, 32'd0);
`endif
  endtask

  // Waits for valid, checks payload/latency, holds decode off for 'stall'
  // cycles and then completes exactly one transfer.
  task automatic serviceInst(input int stall, input bit spur, input bit mis,
                             input int exp_lat, input logic [31:0] exp_pc);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (!valid_out_idu && cyc < 200) begin
      if (imem_arvalid) checkOutput("araddr", imem_araddr, {exp_pc[31:2], 2'b00});
      if (mis) checkOutput("mis_no_ar", 32'(imem_arvalid), 32'd0);
      checkOutput("pc_hold", pc, exp_pc);
      if (spur) begin
        npc       = 32'h12345678;
        npc_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("valid_rise", 32'(valid_out_idu), 32'd1);
    checkOutput("latency", 32'(cyc), 32'(exp_lat));
    e = sb.pop_front();
    for (int i = 0; i <= stall; i++) begin
      checkOutput("valid_hold", 32'(valid_out_idu), 32'd1);
      checkOutput("pc", pc, e.pc);
      checkOutput("inst", inst, e.inst);
      checkOutput("fetch_err", 32'(fetch_err), 32'(e.err));
      if (spur) begin
        npc       = 32'h12345678;
        npc_valid = 1'b1;
      end
      ready_in_idu = (i == stall);
      @(posedge clk);
      #1;
    end
    ready_in_idu = 1'b0;
    npc_valid    = 1'b0;
    exp_fetch++;
    checkOutput("one_xfer", 32'(valid_out_idu), 32'd0);
    checkOutput("wbu_ready", 32'(ready_out_wbu), 32'd1);
    checkPerf();
  endtask

  // Hands one next PC to the stage and follows that instruction to decode.
  task automatic applyStimulus(input logic [31:0] next_pc, input int ar_d, input int r_d,
                               input logic [1:0] resp, input int stall, input bit spur);
    exp_t e;
    bit   mis;
    int   lat;
    mis         = (next_pc[1:0] != 2'b00);
    ar_delay    = ar_d;
    r_delay     = r_d;
    resp_mode   = resp;
    spur_rvalid = spur;
    e.pc   = next_pc;
    e.err  = mis || (resp != 2'b00);
    e.inst = e.err ? NOP_INST : instFor(next_pc);
    sb.push_back(e);
    lat = mis ? 0 : ar_d + r_d + 2;
    if (!mis) exp_stall += ar_d + r_d + 2;
    checkOutput("wbu_ready_pre", 32'(ready_out_wbu), 32'd1);
    npc       = next_pc;
    npc_valid = 1'b1;
    @(posedge clk);
    #1;
    npc_valid = 1'b0;
    npc       = 32'h0;
    serviceInst(stall, spur, mis, lat, next_pc);
  endtask

  // Asserts reset now (possibly mid-cycle), checks the cleared outputs,
  // then releases and runs the boot fetch from RESET_PC.
  task automatic resetDut();
    exp_t e;
    rst = 1'b1;
    #1;
    checkOutput("rst_arvalid", 32'(imem_arvalid), 32'd0);
    checkOutput("rst_rready", 32'(imem_rready), 32'd0);
    checkOutput("rst_valid", 32'(valid_out_idu), 32'd0);
    checkOutput("rst_wbu", 32'(ready_out_wbu), 32'd0);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_inst", inst, NOP_INST);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
    checkOutput("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    checkOutput("rst_perf_stall", perf_stall_cnt, 32'd0);
    sb.delete();
    exp_fetch    = 0;
    exp_stall    = 0;
    ready_in_idu = 1'b0;
    npc_valid    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_no_ar", 32'(imem_arvalid), 32'd0);
    ar_delay    = 0;
    r_delay     = 0;
    resp_mode   = 2'b00;
    spur_rvalid = 1'b0;
    e.pc   = RESET_PC;
    e.inst = instFor(RESET_PC);
    e.err  = 1'b0;
    sb.push_back(e);
    exp_stall = 2;
    rst = 1'b0;
    checkOutput("boot_no_ar", 32'(imem_arvalid), 32'd0);
    serviceInst(0, 1'b0, 1'b0, 3, RESET_PC);
  endtask

  // Main sequence
  initial begin
    int cyc;
    rst          = 1'b0;
    ready_in_idu = 1'b0;
    npc          = 32'h0;
    npc_valid    = 1'b0;
    #2;
    resetDut();
    applyStimulus(32'h80000004, 0, 0, 2'b00, 0, 1'b0);
    applyStimulus(32'h80000008, 2, 3, 2'b00, 4, 1'b0);
    applyStimulus(32'h8000000C, 0, 1, 2'b10, 0, 1'b0);
    applyStimulus(32'h80000006, 0, 0, 2'b00, 1, 1'b0);
    applyStimulus(32'h80000010, 2, 1, 2'b00, 2, 1'b1);
    applyStimulus(32'hFFFFFFFC, 0, 0, 2'b00, 1, 1'b0);
    applyStimulus(32'h00000000, 1, 0, 2'b01, 0, 1'b0);
    applyStimulus(32'h80000014, 0, 0, 2'b00, 0, 1'b0);

    ar_delay    = 0;
    r_delay     = 3;
    resp_mode   = 2'b00;
    spur_rvalid = 1'b0;
    checkOutput("wbu_ready_pre", 32'(ready_out_wbu), 32'd1);
    npc       = 32'h80000040;
    npc_valid = 1'b1;
    @(posedge clk);
    #1;
    npc_valid = 1'b0;
    cyc = 0;
    while (!imem_rready && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("resp_reached", 32'(imem_rready), 32'd1);
    #2;
    resetDut();
    applyStimulus(32'h80000020, 1, 1, 2'b00, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage for the multi-cycle core. It sits directly upstream of the decode stage. It issues one instruction read per instruction on an AXI-lite-style read channel to instruction memory. It presents the {pc, inst} pair to decode with a valid/ready handshake, then waits for the write-back stage to hand back the next PC before starting the next fetch. Only one instruction is in flight at any time.

Parameters:
RESET_PC, 32'h80000000, PC loaded on reset and used for the first fetch.
NOP_INST, 32'h00000013, instruction word substituted when a fetch faults.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
imem_araddr  out  32  read address, always {pc[31:2],2'b00}.
imem_arvalid  out  1  read address valid.
imem_arready  in  1  memory accepts address.
imem_rdata  in  32  read data.
imem_rresp  in  2  read response; 2'b00 = OKAY, anything else = error.
imem_rvalid  in  1  read data valid.
imem_rready  out  1  fetch accepts read data.
pc  out  32  PC of the instruction presented to decode.
inst  out  32  instruction word presented to decode.
fetch_err  out  1  presented instruction faulted (bus error or misaligned PC).
valid_out_idu  out  1  {pc, inst, fetch_err} valid to decode.
ready_in_idu  in  1  decode ready.
npc  in  32  next PC from write-back.
npc_valid  in  1  write-back offers npc.
ready_out_wbu  out  1  fetch will accept npc.
perf_fetch_cnt  out  32  completed decode transfers (optional feature).
perf_stall_cnt  out  32  cycles spent waiting on memory (optional feature).

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high and forces the following:
  - state = BOOT, pc = RESET_PC, inst = NOP_INST, fetch_err = 0.
  - All handshake outputs = 0; perf counters = 0.
- States (3-bit encoding): BOOT, REQ, RESP, SEND, WAIT_NPC. All handshake outputs are decoded from state only.
- BOOT: unconditionally moves to REQ on the next clock. Memory sees no request while rst is high or during the first post-reset cycle.
- REQ: imem_arvalid = 1.
  - imem_araddr stays stable until the handshake completes.
  - On imem_arvalid && imem_arready, go to RESP.
  - imem_rvalid is ignored while in REQ.
- RESP: imem_rready = 1. On imem_rvalid:
  - If imem_rresp == 00: inst <= imem_rdata, fetch_err <= 0.
  - Otherwise: inst <= NOP_INST, fetch_err <= 1.
  - Go to SEND.
- SEND: valid_out_idu = 1.
  - pc, inst and fetch_err are held constant until the transfer completes.
  - Transfer happens on valid_out_idu && ready_in_idu, including when ready_in_idu is high in the first SEND cycle. Then go to WAIT_NPC.
- WAIT_NPC: ready_out_wbu = 1. On npc_valid, pc <= npc.
  - If npc[1:0] != 0: skip memory entirely; inst <= NOP_INST, fetch_err <= 1, go to SEND.
  - Otherwise go to REQ.
- npc_valid outside WAIT_NPC has no effect (ready_out_wbu = 0).
- Latency with zero-wait memory:
  - BOOT→REQ→RESP→SEND, so valid_out_idu rises 3 cycles after reset release.
  - Each subsequent instruction: npc accepted → valid_out_idu rises 2 cycles later.
- Reset mid-transaction: an outstanding read is abandoned and never accepted (rready = 0 in BOOT). Memory is reset by the same rst.
- No PC arithmetic in this block; pc wraps only via the supplied npc.

Optional Feature:
Macro IFU_PERF_EN.
- Defined:
  - perf_fetch_cnt increments by 1 on every decode transfer.
  - perf_stall_cnt increments by 1 on every cycle spent in REQ or RESP.
  - Both are 32-bit and wrap from 32'hFFFFFFFF to 0.
- Undefined: both ports are driven constant 0 and no counter flops exist. Port list is unchanged.

Test Plan:
- Zero-wait memory: release reset, memory returns 32'h00100093 → valid_out_idu high at cycle 3 with pc=32'h80000000, inst=32'h00100093, fetch_err=0; araddr=32'h80000000.
- Backpressure on both sides: arready delayed 2 cycles, rvalid delayed 3, ready_in_idu low 4 cycles → araddr, pc and inst stable throughout; exactly one transfer; perf_stall_cnt=7 with IFU_PERF_EN.
- Bus error: rresp=2'b10 → inst=32'h00000013, fetch_err=1, valid_out_idu=1.
- Misaligned npc: npc=32'h80000006 in WAIT_NPC → no arvalid pulse; SEND next cycle with pc=32'h80000006, fetch_err=1.
- Spurious inputs: npc_valid pulsed during REQ/RESP/SEND and rvalid pulsed during REQ → all ignored; pc is not updated.
- Async reset: assert rst mid-RESP between clock edges → outputs clear immediately; first post-reset araddr=32'h80000000; perf counters=0.
